uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Receive side of the UART link; decodes frames produced by the team's transmitter. Frame format is start(0), data bits 0..7 LSB first, even parity bit (XOR of the 8 data bits), stop(1). The block oversamples RxD at 16x the baud rate using an internal tick generator selected by baud_select. It presents each received byte with a one-cycle valid strobe plus sticky parity and framing error flags.

Parameters:
CLK_HZ, 50000000, system clock frequency; sets the tick divisors.
OVERSAMPLE, 16, number of sample ticks per bit; only 16 is supported.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
baud_select  input  3  rate select: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200
Rx_EN  input  1  receiver enable
RxD  input  1  serial line, asynchronous to clk, idles high
Rx_DATA  output  8  last received byte; held until the next frame completes
Rx_VALID  output  1  one-clk pulse when an error-free frame completes
Rx_PERROR  output  1  parity error of the last frame; sticky
Rx_FERROR  output  1  framing (stop bit) error of the last frame; sticky

Behaviour:
- Reset (reset=0, asynchronous): state=OFF, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, tick counter=0, synchroniser flops=1.
- RxD passes through a 2-flop synchroniser (reset value 1). All decoding uses the synchronised value, which adds 2 clk of latency.
- Tick generator: free-running divisor counter. Divisor = round(CLK_HZ/(16*baud)); at 50 MHz the values are 10417, 2604, 651, 326, 163, 81, 54, 27. Emits a 1-clk sample tick when the count wraps.
- The tick generator restarts from 0 at start-edge detection, so sample phase is aligned to the frame.
- baud_select is sampled at start-edge detection and held for the whole frame.
- States and transitions:
  - OFF: Rx_EN=1 -> IDLE.
  - IDLE: wait for a falling edge of synchronised RxD (1->0) -> START; clear the tick and sub-bit counters.
  - START: at tick 8 (mid-bit), if RxD=0 -> DATA with bit_idx=0. If RxD=1, treat as a false start -> IDLE; no flags change.
  - DATA: every 16 ticks from the START mid-point, shift RxD into shift_reg[bit_idx] (LSB first). After bit_idx=7 -> PARITY.
  - PARITY: sample 16 ticks later; perr = sample XOR (^shift_reg) -> STOP.
  - STOP: sample 16 ticks later; ferr = (sample==0).
    - Load Rx_DATA<=shift_reg, Rx_PERROR<=perr, Rx_FERROR<=ferr.
    - Pulse Rx_VALID for 1 clk only if perr=0 and ferr=0.
    - Next state: IDLE if Rx_EN=1, else OFF.
    - If ferr=1, wait in STOP until RxD is high before returning to IDLE, so no spurious start is taken from a held-low line (break).
- Error flags are sticky: they hold until the next frame's STOP evaluation, or until reset.
- Rx_EN=0 in any state other than OFF: abort immediately to OFF on the next clk. Rx_DATA and the flags are unchanged; no Rx_VALID.
- Reset mid-frame: immediate return to the reset values; any partial byte is discarded.
- Rx_VALID is never asserted in two consecutive cycles. Rx_DATA is stable while Rx_VALID=1.
- Line sampling is single-sample at mid-bit; no majority vote.

Test Plan:
- Clean frame at 115200 (baud_select=111, 432 clk/bit): send 8'hA5 with parity 0 and stop 1 -> one Rx_VALID pulse, Rx_DATA=8'hA5, PERROR=0, FERROR=0.
- Parity error: send 8'h01 with parity bit 0 -> Rx_DATA=8'h01, Rx_PERROR=1, no Rx_VALID. Then send 8'h03 with correct parity 0 -> PERROR clears and Rx_VALID pulses.
- Framing error: send 8'h3C with the stop bit low, then hold RxD low for 3 bit times -> Rx_FERROR=1, no Rx_VALID, and no second frame decoded until RxD returns high.
- False start: glitch RxD low for 100 clk in IDLE -> state returns to IDLE, no outputs change. A following 8'h7E frame is received correctly.
- Back-to-back bytes 8'h00 and 8'hFF at 9600 (baud_select=011) with no idle gap -> two Rx_VALID pulses with data 00 then FF.
- Rx_EN dropped during DATA of a frame, or reset pulsed low mid-frame -> no Rx_VALID, Rx_DATA keeps its previous value (or 00 after reset). Re-enabling then gives correct reception of 8'h5A.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receive path.
// Recovers bytes from a start / 8 data (LSB first) / even parity / stop frame
// using 16x oversampling and a single mid-bit sample per bit.
// A one-clk valid strobe marks a clean frame; parity and framing flags are
// sticky and reflect only the most recently completed frame.
module uart_receiver #(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   // Sample-tick divisor, rounded to nearest: round(CLK_HZ / (OVERSAMPLE * baud)).
   function automatic int baud_div(input int baud);
      return (CLK_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
   endfunction

   localparam int DIV_MAX = baud_div(300);
   localparam int CW      = $clog2(DIV_MAX + 1);
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int HALF    = OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      S_OFF,
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK   // stop bit was low: hold here until the line is released
   } state_t;

   state_t        state_q, state_d;
   logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [SW-1:0] sub_cnt_q, sub_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          perr_q, perr_d;
   logic [2:0]    baud_q, baud_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_perror_q, rx_perror_d;
   logic          rx_ferror_q, rx_ferror_d;

   logic [CW-1:0] div_m1;
   logic          tick;
   logic          mid_tick;
   logic          bit_tick;
   logic          fall;

   // Two-flop synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= RxD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   assign fall = rxd_prev_q & ~rxd_sync_q;

   // Tick period for the rate latched when the current frame started
   always_comb begin
      case (baud_q)
         3'd0:    div_m1 = CW'(baud_div(300) - 1);
         3'd1:    div_m1 = CW'(baud_div(1200) - 1);
         3'd2:    div_m1 = CW'(baud_div(4800) - 1);
         3'd3:    div_m1 = CW'(baud_div(9600) - 1);
         3'd4:    div_m1 = CW'(baud_div(19200) - 1);
         3'd5:    div_m1 = CW'(baud_div(38400) - 1);
         3'd6:    div_m1 = CW'(baud_div(57600) - 1);
         default: div_m1 = CW'(baud_div(115200) - 1);
      endcase
   end

   assign tick     = (tick_cnt_q >= div_m1);
   assign mid_tick = tick && (sub_cnt_q == SW'(HALF - 1));
   assign bit_tick = tick && (sub_cnt_q == SW'(OVERSAMPLE - 1));

   // Next-state, counters, datapath and output register updates
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
      sub_cnt_d   = sub_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      perr_d      = perr_q;
      baud_d      = baud_q;
      rx_data_d   = rx_data_q;
      rx_perror_d = rx_perror_q;
      rx_ferror_d = rx_ferror_q;
      rx_valid_d  = 1'b0;

      if (tick) begin
         sub_cnt_d = (sub_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : sub_cnt_q + SW'(1);
      end

      if (!Rx_EN && state_q != S_OFF) begin
         // Disable aborts any frame in flight without touching the outputs
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF: begin
               if (Rx_EN) state_d = S_IDLE;
            end
            S_IDLE: begin
               if (fall) begin
                  // Align the sample phase to the start edge and lock the rate
                  state_d    = S_START;
                  tick_cnt_d = '0;
                  sub_cnt_d  = '0;
                  baud_d     = baud_select;
               end
            end
            S_START: begin
               if (mid_tick) begin
                  // From here on every 16th tick lands mid-bit
                  sub_cnt_d = '0;
                  if (rxd_sync_q) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d   = S_DATA;
                     bit_idx_d = 3'd0;
                  end
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  shift_d[bit_idx_q] = rxd_sync_q;
                  if (bit_idx_q == 3'd7) state_d = S_PARITY;
                  else                   bit_idx_d = bit_idx_q + 3'd1;
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  perr_d  = rxd_sync_q ^ (^shift_q);
                  state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  rx_data_d   = shift_q;
                  rx_perror_d = perr_q;
                  rx_ferror_d = ~rxd_sync_q;
                  rx_valid_d  = ~perr_q & rxd_sync_q;
                  state_d     = rxd_sync_q ? S_IDLE : S_BREAK;
               end
            end
            S_BREAK: begin
               if (rxd_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_OFF;
         tick_cnt_q  <= '0;
         sub_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         perr_q      <= 1'b0;
         baud_q      <= 3'd0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_perror_q <= 1'b0;
         rx_ferror_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         sub_cnt_q   <= sub_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         perr_q      <= perr_d;
         baud_q      <= baud_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_perror_q <= rx_perror_d;
         rx_ferror_q <= rx_ferror_d;
      end
   end

   assign Rx_DATA   = rx_data_q;
   assign Rx_VALID  = rx_valid_q;
   assign Rx_PERROR = rx_perror_q;
   assign Rx_FERROR = rx_ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives serial frames bit by bit and checks the receiver
// against a frame-level model (expected byte, flags, valid count, queue of
// bytes that must be strobed).
module tb_uart_receiver;

   localparam int CLK_HZ = 8000000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] baud_select = 3'd7;
   logic       rx_en = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_perror;
   logic       rx_ferror;

   always #5 clk = ~clk;

   uart_receiver #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Rx_EN       (rx_en),
      .RxD         (rxd),
      .Rx_DATA     (rx_data),
      .Rx_VALID    (rx_valid),
      .Rx_PERROR   (rx_perror),
      .Rx_FERROR   (rx_ferror)
   );

   int errors = 0;
   int checks = 0;

   // Frame-level model
   logic [7:0] exp_data  = 8'h00;
   logic       exp_perr  = 1'b0;
   logic       exp_ferr  = 1'b0;
   int         exp_valid = 0;
   logic [7:0] exp_q[$];
   int         obs_valid = 0;
   bit         busy = 1'b1;
   bit         prev_valid = 1'b0;

   function automatic int baud_rate(input logic [2:0] sel);
      case (sel)
         3'd0: return 300;
         3'd1: return 1200;
         3'd2: return 4800;
         3'd3: return 9600;
         3'd4: return 19200;
         3'd5: return 38400;
         3'd6: return 57600;
         default: return 115200;
      endcase
   endfunction

   // Clocks per bit: 16 ticks of the nearest-integer tick period
   function automatic int bit_clks(input logic [2:0] sel);
      real d;
      d = real'(CLK_HZ) / (16.0 * real'(baud_rate(sel)));
      return 16 * $rtoi(d + 0.5);
   endfunction

   task automatic check_lit(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // Per-cycle comparison against the model
   always begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
         obs_valid++;
         checks++;
         if (prev_valid || rx_perror || rx_ferror || exp_q.size() == 0) begin
            errors++;
            $display("FAIL valid_strobe: prev=%0b perr=%0b ferr=%0b pending=%0d at %0t",
                     prev_valid, rx_perror, rx_ferror, exp_q.size(), $time);
         end else begin
            logic [7:0] want;
            want = exp_q.pop_front();
            if (rx_data !== want) begin
               errors++;
               $display("FAIL valid_data: got %02h expected %02h at %0t", rx_data, want, $time);
            end
         end
      end
      prev_valid = rx_valid;
      if (!busy) begin
         checks++;
         if (rx_data !== exp_data || rx_perror !== exp_perr || rx_ferror !== exp_ferr ||
             obs_valid != exp_valid) begin
            errors++;
            $display("FAIL outputs: data=%02h perr=%0b ferr=%0b valids=%0d expected data=%02h perr=%0b ferr=%0b valids=%0d at %0t",
                     rx_data, rx_perror, rx_ferror, obs_valid,
                     exp_data, exp_perr, exp_ferr, exp_valid, $time);
         end
      end
   end

   task automatic idle_bits(input int n, input logic [2:0] sel);
      repeat (n * bit_clks(sel)) @(negedge clk);
   endtask

   // Full frame; the model takes the new result three quarters into the stop bit
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                             input logic [2:0] sel, input int hold_bits);
      int bc;
      bc = bit_clks(sel);
      baud_select = sel;
      if (!bad_par && stop) exp_q.push_back(d);
      busy = 1'b1;
      rxd = 1'b0;
      repeat (bc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (bc) @(negedge clk);
      end
      rxd = (^d) ^ bad_par;
      repeat (bc) @(negedge clk);
      rxd = stop;
      repeat (bc * 3 / 4) @(negedge clk);
      exp_data = d;
      exp_perr = bad_par;
      exp_ferr = !stop;
      if (!bad_par && stop) exp_valid++;
      busy = 1'b0;
      repeat (bc - bc * 3 / 4) @(negedge clk);
      repeat (hold_bits * bc) @(negedge clk);
      rxd = 1'b1;
      $display("frame %02h par_err=%0b stop=%0b sel=%0d -> data=%02h perr=%0b ferr=%0b valids=%0d",
               d, bad_par, stop, sel, rx_data, rx_perror, rx_ferror, obs_valid);
   endtask

   // Start bit plus the first nbits data bits, then the caller abandons the frame
   task automatic partial_frame(input logic [7:0] d, input int nbits, input logic [2:0] sel);
      int bc;
      bc = bit_clks(sel);
      baud_select = sel;
      rxd = 1'b0;
      repeat (bc) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         rxd = d[i];
         repeat (bc) @(negedge clk);
      end
   endtask

   initial begin
      // Reset values
      repeat (5) @(negedge clk);
      check_lit("reset_data", rx_data, 8'h00);
      check_lit("reset_valid", rx_valid, 0);
      check_lit("reset_perr", rx_perror, 0);
      check_lit("reset_ferr", rx_ferror, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      busy = 1'b0;
      idle_bits(2, 3'd7);

      // Clean frame at 115200
      send_frame(8'hA5, 1'b0, 1'b1, 3'd7, 0);
      check_lit("a5_data", rx_data, 8'hA5);
      check_lit("a5_flags", {rx_perror, rx_ferror}, 0);
      check_lit("a5_valids", obs_valid, 1);
      idle_bits(2, 3'd7);

      // Parity error, then a clean frame clears the flag
      send_frame(8'h01, 1'b1, 1'b1, 3'd7, 0);
      check_lit("perr_data", rx_data, 8'h01);
      check_lit("perr_flag", rx_perror, 1);
      check_lit("perr_valids", obs_valid, 1);
      idle_bits(2, 3'd7);
      send_frame(8'h03, 1'b0, 1'b1, 3'd7, 0);
      check_lit("perr_cleared", rx_perror, 0);
      check_lit("v03_valids", obs_valid, 2);
      idle_bits(2, 3'd7);

      // Framing error with the line held low afterwards (break)
      send_frame(8'h3C, 1'b0, 1'b0, 3'd7, 3);
      check_lit("ferr_flag", rx_ferror, 1);
      check_lit("ferr_data", rx_data, 8'h3C);
      check_lit("ferr_valids", obs_valid, 2);
      idle_bits(2, 3'd7);

      // False start: glitch shorter than half a bit
      rxd = 1'b0;
      repeat (bit_clks(3'd7) / 4) @(negedge clk);
      rxd = 1'b1;
      idle_bits(2, 3'd7);
      send_frame(8'h7E, 1'b0, 1'b1, 3'd7, 0);
      check_lit("7e_data", rx_data, 8'h7E);
      check_lit("7e_ferr_cleared", rx_ferror, 0);
      idle_bits(1, 3'd3);

      // Back-to-back at 9600
      send_frame(8'h00, 1'b0, 1'b1, 3'd3, 0);
      send_frame(8'hFF, 1'b0, 1'b1, 3'd3, 0);
      check_lit("b2b_data", rx_data, 8'hFF);
      check_lit("b2b_valids", obs_valid, 5);
      idle_bits(2, 3'd7);

      // Rx_EN dropped during data bits, outputs must hold
      partial_frame(8'hC3, 4, 3'd7);
      rx_en = 1'b0;
      rxd = 1'b1;
      idle_bits(12, 3'd7);
      rx_en = 1'b1;
      idle_bits(2, 3'd7);
      check_lit("abort_data", rx_data, 8'hFF);
      send_frame(8'h5A, 1'b0, 1'b1, 3'd7, 0);
      check_lit("5a_after_abort", rx_data, 8'h5A);
      idle_bits(2, 3'd7);

      // Reset pulsed mid-frame
      busy = 1'b1;
      partial_frame(8'h96, 4, 3'd7);
      reset = 1'b0;
      rxd = 1'b1;
      exp_data = 8'h00;
      exp_perr = 1'b0;
      exp_ferr = 1'b0;
      repeat (3) @(negedge clk);
      check_lit("midreset_data", rx_data, 8'h00);
      reset = 1'b1;
      idle_bits(2, 3'd7);
      busy = 1'b0;
      idle_bits(1, 3'd7);
      send_frame(8'h5A, 1'b0, 1'b1, 3'd7, 0);
      check_lit("5a_after_reset", rx_data, 8'h5A);
      idle_bits(2, 3'd7);

      // Randomized frames across the faster rates
      for (int n = 0; n < 16; n++) begin
         logic [7:0] d;
         bit         bp;
         bit         st;
         logic [2:0] sel;
         int         gap;
         d   = 8'($urandom_range(0, 255));
         bp  = ($urandom_range(0, 5) == 0);
         st  = ($urandom_range(0, 5) != 0);
         sel = 3'(5 + $urandom_range(0, 2));
         send_frame(d, bp, st, sel, 0);
         gap = st ? $urandom_range(0, 2) : 1 + $urandom_range(0, 2);
         idle_bits(gap, sel);
      end
      idle_bits(2, 3'd7);
      check_lit("pending_strobes", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
